// File: rtl/alu_pkg.sv
// Shared integer-datapath definitions: adder geometry, word types and
// the second-level carry-lookahead function used by the adder top.
package alu_pkg;

  localparam int ADD_WIDTH  = 32;
  localparam int CLA_GROUP  = 4;
  localparam int NUM_GROUPS = ADD_WIDTH / CLA_GROUP;

  typedef logic [ADD_WIDTH-1:0]  word_t;
  typedef logic [NUM_GROUPS-1:0] grp_t;
  typedef logic [NUM_GROUPS:0]   gcarry_t;

  typedef struct packed {
    logic  co;
    word_t s;
  } sum_t;

  // Flat sum-of-products lookahead: each group carry-in is an OR of
  // generate terms masked by the propagates above them, plus C0 masked
  // by every propagate below. No term depends on another carry.
  function automatic gcarry_t cla_carries(
    input grp_t g,
    input grp_t p,
    input logic c0
  );
    gcarry_t c;
    logic    term;
    c    = '0;
    c[0] = c0;
    for (int k = 0; k < NUM_GROUPS; k++) begin
      term = c0;
      for (int m = 0; m <= k; m++) begin
        term = term & p[m];
      end
      c[k+1] = term;
      for (int j = 0; j <= k; j++) begin
        term = g[j];
        for (int m = j + 1; m <= k; m++) begin
          term = term & p[m];
        end
        c[k+1] = c[k+1] | term;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead group: local sum bits plus group
// generate/propagate for the second lookahead level.
module cla4
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       G,
  output logic       P
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;

    c[0] = cin;
    c[1] = g[0]
         | (p[0] & cin);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);

    s = p ^ c;

    G = g[3]
      | (p[3] & g[2])
      | (p[3] & p[2] & g[1])
      | (p[3] & p[2] & p[1] & g[0]);
    P = &p;
  end

endmodule

// File: rtl/adc32_cla.sv
// Registered 32-bit two-level carry-lookahead adder with carry in/out;
// one cycle latency, async active-high reset clears {Co, S}.
module adc32_cla
  import alu_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  localparam int NG = WIDTH / GROUP;

  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   grp_c;
  word_t         sum_raw;
  sum_t          sum_d;
  sum_t          sum_q;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla4 u_cla4 (
      .a   (A[GROUP*k +: GROUP]),
      .b   (B[GROUP*k +: GROUP]),
      .cin (grp_c[k]),
      .s   (sum_raw[GROUP*k +: GROUP]),
      .G   (grp_g[k]),
      .P   (grp_p[k])
    );
  end

  always_comb begin
    grp_c    = cla_carries(grp_g, grp_p, C0);
    sum_d.co = grp_c[NG];
    sum_d.s  = sum_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign S  = sum_q.s;
  assign Co = sum_q.co;

endmodule

// File: tb/tb_adc32_cla.sv
// Scoreboard bench for adc32_cla: driver queues 33-bit reference sums,
// monitor pops one per captured vector and compares {Co, S}.
module tb_adc32_cla;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        C0;
  logic [31:0] S;
  logic        Co;
  logic        tb_vld;

  logic [32:0] exp_q[$];
  int          n_chk;
  int          n_pass;

  adc32_cla dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .C0  (C0),
    .S   (S),
    .Co  (Co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [32:0] act,
                       input logic [32:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic c);
    @(negedge clk);
    A      = a;
    B      = b;
    C0     = c;
    tb_vld = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {32'd0, c});
  endtask

  // monitor: one result per edge that captured a queued vector
  always @(posedge clk) begin
    logic        pend;
    logic [32:0] e;
    pend = tb_vld && !rst;
    #1;
    if (pend) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", {Co, S}, 33'h1_FFFF_FFFF ^ {Co, S});
      end else begin
        e = exp_q.pop_front();
        check("sum", {Co, S}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    A      = '0;
    B      = '0;
    C0     = 1'b0;
    tb_vld = 1'b0;

    repeat (2) @(posedge clk);
    #1 check("reset_hold", {Co, S}, 33'd0);

    // release with zero operands: first edge captures 0+0+0
    @(negedge clk);
    rst    = 1'b0;
    tb_vld = 1'b1;
    exp_q.push_back(33'd0);

    drive(32'd100, 32'd123, 1'b0);
    #1 check("no_early_update", {Co, S}, 33'd0);
    drive(32'h7FFF_FFFF, 32'd3, 1'b0);
    drive(32'd100, 32'd123, 1'b1);
    drive(32'h7FFF_FFFF, 32'd3, 1'b1);
    drive(32'hFFFF_FFFF, 32'd0, 1'b1);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    drive(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0);
    drive(32'h0000_0000, 32'h0000_0000, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      if (i == 500) begin
        // async reset between edges; the queued vector is discarded
        #2 rst = 1'b1;
        #1 check("async_reset_now", {Co, S}, 33'd0);
        tb_vld = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 check("async_reset_held", {Co, S}, 33'd0);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    tb_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 33'(exp_q.size()), 33'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
